// File: rtl/uart_tx_ctrl.sv
// uart_tx_ctrl -- UART transmit frame sequencer.
// Drives an external serializer through start / data / parity / stop bits
// and muxes the serial line. Defining UART_TX_CTRL_HOLD_EN adds a one-entry
// request holding register so a request can be taken while a frame is busy.
module uart_tx_ctrl #(
  parameter int WIDTH = 8,
  parameter int WDOG  = WIDTH + 2
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] P_DATA,
  input  logic             Data_Valid,
  input  logic             PAR_EN,
  input  logic             PAR_TYP,
  input  logic             ser_data,
  input  logic             ser_done,
  output logic             ser_en,
  output logic [1:0]       mux_sel,
  output logic             TX_OUT,
  output logic             busy,
  output logic             data_accept,
  output logic             frame_err
);

  localparam int CNT_W = $clog2(WDOG + 1);

  localparam logic [1:0] SEL_START  = 2'd0;
  localparam logic [1:0] SEL_DATA   = 2'd1;
  localparam logic [1:0] SEL_PARITY = 2'd2;
  localparam logic [1:0] SEL_STOP   = 2'd3;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t           state, state_nxt;
  logic             par_bit, par_bit_nxt;
  logic             par_en, par_en_nxt;
  logic             frame_err_nxt;
  logic             accept_nxt;
  logic [CNT_W-1:0] wd_cnt, wd_cnt_nxt;

`ifdef UART_TX_CTRL_HOLD_EN
  logic hold_full, hold_full_nxt;
  logic hold_par, hold_par_nxt;
  logic hold_pen, hold_pen_nxt;
`endif

  // Parity bit for a word: even parity gives XOR of the bits, odd inverts it.
  function automatic logic calc_par(input logic [WIDTH-1:0] d, input logic typ);
    return (^d) ^ typ;
  endfunction

  // Line select associated with a state; idle shares the stop (mark) level.
  function automatic logic [1:0] sel_of(input state_t s);
    case (s)
      START:   return SEL_START;
      DATA:    return SEL_DATA;
      PARITY:  return SEL_PARITY;
      default: return SEL_STOP;
    endcase
  endfunction

  // Next-state logic, request capture and watchdog.
  always_comb begin
    state_nxt     = state;
    par_bit_nxt   = par_bit;
    par_en_nxt    = par_en;
    wd_cnt_nxt    = wd_cnt;
    frame_err_nxt = frame_err;
    accept_nxt    = 1'b0;
`ifdef UART_TX_CTRL_HOLD_EN
    hold_full_nxt = hold_full;
    hold_par_nxt  = hold_par;
    hold_pen_nxt  = hold_pen;
`endif
    case (state)
      IDLE: begin
        if (Data_Valid) begin
          state_nxt   = START;
          par_bit_nxt = calc_par(P_DATA, PAR_TYP);
          par_en_nxt  = PAR_EN;
          accept_nxt  = 1'b1;
        end
      end
      START: begin
        state_nxt  = DATA;
        wd_cnt_nxt = '0;
      end
      DATA: begin
        wd_cnt_nxt = wd_cnt + 1'b1;
        // A real ser_done beats a watchdog expiry in the same cycle.
        if (ser_done) begin
          state_nxt = par_en ? PARITY : STOP;
        end else if (wd_cnt == CNT_W'(WDOG - 1)) begin
          state_nxt     = STOP;
          frame_err_nxt = 1'b1;
        end
      end
      PARITY: begin
        state_nxt = STOP;
      end
      STOP: begin
`ifdef UART_TX_CTRL_HOLD_EN
        // A held request launches first; a concurrent Data_Valid is dropped.
        if (hold_full) begin
          state_nxt     = START;
          par_bit_nxt   = hold_par;
          par_en_nxt    = hold_pen;
          hold_full_nxt = 1'b0;
        end else
`endif
        if (Data_Valid) begin
          state_nxt   = START;
          par_bit_nxt = calc_par(P_DATA, PAR_TYP);
          par_en_nxt  = PAR_EN;
          accept_nxt  = 1'b1;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
`ifdef UART_TX_CTRL_HOLD_EN
    if (((state == START) || (state == DATA) || (state == PARITY)) &&
        Data_Valid && !hold_full) begin
      hold_full_nxt = 1'b1;
      hold_par_nxt  = calc_par(P_DATA, PAR_TYP);
      hold_pen_nxt  = PAR_EN;
      accept_nxt    = 1'b1;
    end
`endif
  end

  // State register plus outputs registered from the next state.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state       <= IDLE;
      par_bit     <= 1'b0;
      par_en      <= 1'b0;
      wd_cnt      <= '0;
      frame_err   <= 1'b0;
      data_accept <= 1'b0;
      ser_en      <= 1'b0;
      mux_sel     <= SEL_STOP;
      busy        <= 1'b0;
    end else begin
      state       <= state_nxt;
      par_bit     <= par_bit_nxt;
      par_en      <= par_en_nxt;
      wd_cnt      <= wd_cnt_nxt;
      frame_err   <= frame_err_nxt;
      data_accept <= accept_nxt;
      ser_en      <= (state_nxt == START) || (state_nxt == DATA);
      mux_sel     <= sel_of(state_nxt);
      busy        <= (state_nxt != IDLE);
    end
  end

`ifdef UART_TX_CTRL_HOLD_EN
  // One-entry holding register for a request taken mid-frame.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      hold_full <= 1'b0;
      hold_par  <= 1'b0;
      hold_pen  <= 1'b0;
    end else begin
      hold_full <= hold_full_nxt;
      hold_par  <= hold_par_nxt;
      hold_pen  <= hold_pen_nxt;
    end
  end
`endif

  // Serial line mux; data bits pass straight through from the serializer.
  always_comb begin
    TX_OUT = 1'b1;
    case (mux_sel)
      SEL_START:  TX_OUT = 1'b0;
      SEL_DATA:   TX_OUT = ser_data;
      SEL_PARITY: TX_OUT = par_bit;
      default:    TX_OUT = 1'b1;
    endcase
  end

endmodule
